// File: rtl/polar_enc_pkg.sv
// Shared definitions for the polar encoder chain.
// Codeword/message widths, serializer state and frame counter width.
package polar_enc_pkg;

    localparam int M_DEF     = 5;
    localparam int LM_DEF    = 2;
    localparam int CNT_W_DEF = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_e;

endpackage

// File: rtl/cw_fifo.sv
// DEPTH x W synchronous codeword FIFO with occupancy count.
// Reads are combinational from the head entry; pops and pushes are guarded.
module cw_fifo
    import polar_enc_pkg::*;
#(
    parameter int W     = M_DEF,
    parameter int DEPTH = 2,
    parameter int CB    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [W-1:0]  wr_data,
    input  logic          wr_en,
    input  logic          rd_en,
    output logic [W-1:0]  rd_data,
    output logic [CB-1:0] count,
    output logic          full,
    output logic          empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CB'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = wr_en && !full;
    assign do_pop  = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/codeword_serializer.sv
// Serializes M-bit codewords onto a one-bit valid/ready stream.
// Queues codewords in a small FIFO and flags first/last bit of each.
module codeword_serializer
    import polar_enc_pkg::*;
#(
    parameter int M         = M_DEF,
    parameter int DEPTH     = 2,
    parameter bit MSB_FIRST = 1'b1,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [M-1:0]     cw_in,
    input  logic             cw_valid,
    output logic             cw_ready,
    output logic             bit_out,
    output logic             bit_valid,
    input  logic             bit_ready,
    output logic             bit_sof,
    output logic             bit_eof,
    output logic [CNT_W-1:0] frame_cnt,
    output logic             busy
);

    localparam int IDX_W = $clog2(M);
    localparam int CB    = $clog2(DEPTH + 1);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(M - 1);

    ser_state_e       state;
    logic [M-1:0]     sreg;
    logic [IDX_W-1:0] bit_idx;
    logic [IDX_W-1:0] nxt_idx;
    logic [M-1:0]     head;
    logic [CB-1:0]    count;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             last_xfer;

    function automatic logic pick(
        input logic [M-1:0]     w,
        input logic [IDX_W-1:0] i
    );
        if (MSB_FIRST) begin
            return w[IDX_W'(M - 1 - int'(i))];
        end
        return w[i];
    endfunction

    // cw_ready depends only on the registered count, never on bit_ready.
    assign cw_ready  = !full;
    assign push      = cw_valid && cw_ready;
    assign nxt_idx   = bit_idx + 1'b1;
    assign last_xfer = (state == SHIFT) && bit_ready && (bit_idx == LAST);
    assign pop       = !empty && ((state == IDLE) || last_xfer);
    assign busy      = (state == SHIFT) || (count != '0);

    cw_fifo #(
        .W     (M),
        .DEPTH (DEPTH),
        .CB    (CB)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .wr_data (cw_in),
        .wr_en   (push),
        .rd_en   (pop),
        .rd_data (head),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            sreg      <= '0;
            bit_idx   <= '0;
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
            bit_sof   <= 1'b0;
            bit_eof   <= 1'b0;
            frame_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!empty) begin
                        state     <= SHIFT;
                        sreg      <= head;
                        bit_idx   <= '0;
                        bit_out   <= pick(head, '0);
                        bit_valid <= 1'b1;
                        bit_sof   <= 1'b1;
                        bit_eof   <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (bit_ready) begin
                        if (bit_idx == LAST) begin
                            frame_cnt <= frame_cnt + 1'b1;
                            // Chain straight into the next codeword.
                            if (!empty) begin
                                sreg      <= head;
                                bit_idx   <= '0;
                                bit_out   <= pick(head, '0);
                                bit_sof   <= 1'b1;
                                bit_eof   <= 1'b0;
                            end else begin
                                state     <= IDLE;
                                bit_idx   <= '0;
                                bit_out   <= 1'b0;
                                bit_valid <= 1'b0;
                                bit_sof   <= 1'b0;
                                bit_eof   <= 1'b0;
                            end
                        end else begin
                            bit_idx <= nxt_idx;
                            bit_out <= pick(sreg, nxt_idx);
                            bit_sof <= 1'b0;
                            bit_eof <= (nxt_idx == LAST);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_codeword_serializer.sv
// Directed bench for codeword_serializer (MSB-first and LSB-first).
// Expected bit streams and flags are hand-derived constants.
module tb_codeword_serializer;

    logic        clk;
    logic        rst;
    logic [4:0]  cw_in;
    logic        cw_valid;
    logic        cw_ready;
    logic        bit_out;
    logic        bit_valid;
    logic        bit_ready;
    logic        bit_sof;
    logic        bit_eof;
    logic [15:0] frame_cnt;
    logic        busy;

    logic [4:0]  l_cw_in;
    logic        l_cw_valid;
    logic        l_cw_ready;
    logic        l_bit_out;
    logic        l_bit_valid;
    logic        l_bit_ready;
    logic        l_bit_sof;
    logic        l_bit_eof;
    logic [15:0] l_frame_cnt;
    logic        l_busy;

    logic use_lsb;
    logic o_valid, o_bit, o_sof, o_eof;

    int checks;
    int failures;

    assign o_valid = use_lsb ? l_bit_valid : bit_valid;
    assign o_bit   = use_lsb ? l_bit_out   : bit_out;
    assign o_sof   = use_lsb ? l_bit_sof   : bit_sof;
    assign o_eof   = use_lsb ? l_bit_eof   : bit_eof;

    codeword_serializer #(
        .M(5), .DEPTH(2), .MSB_FIRST(1'b1), .CNT_W(16)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .cw_in     (cw_in),
        .cw_valid  (cw_valid),
        .cw_ready  (cw_ready),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .bit_ready (bit_ready),
        .bit_sof   (bit_sof),
        .bit_eof   (bit_eof),
        .frame_cnt (frame_cnt),
        .busy      (busy)
    );

    codeword_serializer #(
        .M(5), .DEPTH(2), .MSB_FIRST(1'b0), .CNT_W(16)
    ) u_lsb (
        .clk       (clk),
        .rst       (rst),
        .cw_in     (l_cw_in),
        .cw_valid  (l_cw_valid),
        .cw_ready  (l_cw_ready),
        .bit_out   (l_bit_out),
        .bit_valid (l_bit_valid),
        .bit_ready (l_bit_ready),
        .bit_sof   (l_bit_sof),
        .bit_eof   (l_bit_eof),
        .frame_cnt (l_frame_cnt),
        .busy      (l_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks n consecutive transfers; vectors are ordered first bit at n-1.
    task automatic collect(input string tag, input int n,
                           input logic [15:0] bits,
                           input logic [15:0] sofm,
                           input logic [15:0] eofm);
        int k;
        for (int i = 0; i < n; i++) begin
            k = n - 1 - i;
            chk($sformatf("%s_v%0d", tag, i), 32'(o_valid), 32'd1);
            chk($sformatf("%s_b%0d", tag, i), 32'(o_bit), 32'(bits[k]));
            chk($sformatf("%s_s%0d", tag, i), 32'(o_sof), 32'(sofm[k]));
            chk($sformatf("%s_e%0d", tag, i), 32'(o_eof), 32'(eofm[k]));
            tick();
        end
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        cw_valid  = 1'b0;
        bit_ready = 1'b1;
        #3;
        rst = 1'b1;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks      = 0;
        failures    = 0;
        use_lsb     = 1'b0;
        rst         = 1'b0;
        cw_in       = '0;
        cw_valid    = 1'b0;
        bit_ready   = 1'b1;
        l_cw_in     = '0;
        l_cw_valid  = 1'b0;
        l_bit_ready = 1'b1;
        #12;
        chk("rst_valid", 32'(bit_valid), 32'd0);
        chk("rst_out",   32'(bit_out),   32'd0);
        chk("rst_sof",   32'(bit_sof),   32'd0);
        chk("rst_eof",   32'(bit_eof),   32'd0);
        chk("rst_cnt",   32'(frame_cnt), 32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_rdy",   32'(cw_ready),  32'd1);
        rst = 1'b1;
        tick();

        // Single frame
        cw_in    = 5'b10110;
        cw_valid = 1'b1;
        chk("t1_rdy", 32'(cw_ready), 32'd1);
        tick();
        cw_valid = 1'b0;
        chk("t1_lat_v", 32'(bit_valid), 32'd0);
        chk("t1_busy",  32'(busy),      32'd1);
        tick();
        collect("t1", 5, 16'b10110, 16'b10000, 16'b00001);
        chk("t1_endv", 32'(bit_valid), 32'd0);
        chk("t1_cnt",  32'(frame_cnt), 32'd1);
        chk("t1_idle", 32'(busy),      32'd0);

        // Back-to-back
        do_reset();
        cw_in    = 5'b10110;
        cw_valid = 1'b1;
        tick();
        cw_in = 5'b01001;
        tick();
        cw_valid = 1'b0;
        collect("t2", 10, 16'b1011001001, 16'b1000010000, 16'b0000100001);
        chk("t2_endv", 32'(bit_valid), 32'd0);
        chk("t2_cnt",  32'(frame_cnt), 32'd2);

        // Backpressure at bit_idx 2
        do_reset();
        cw_in    = 5'b11100;
        cw_valid = 1'b1;
        tick();
        cw_valid = 1'b0;
        tick();
        collect("t3a", 2, 16'b11, 16'b10, 16'b00);
        bit_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("t3_hold_v%0d", i), 32'(bit_valid), 32'd1);
            chk($sformatf("t3_hold_b%0d", i), 32'(bit_out),   32'd1);
            chk($sformatf("t3_hold_s%0d", i), 32'(bit_sof),   32'd0);
            chk($sformatf("t3_hold_e%0d", i), 32'(bit_eof),   32'd0);
        end
        bit_ready = 1'b1;
        collect("t3b", 3, 16'b100, 16'b000, 16'b001);
        chk("t3_endv", 32'(bit_valid), 32'd0);
        chk("t3_cnt",  32'(frame_cnt), 32'd1);

        // FIFO full
        do_reset();
        bit_ready = 1'b0;
        cw_valid  = 1'b1;
        cw_in     = 5'b11001;
        tick();
        cw_in = 5'b00101;
        tick();
        cw_in = 5'b10011;
        chk("t4_rdy2", 32'(cw_ready), 32'd1);
        tick();
        chk("t4_full", 32'(cw_ready), 32'd0);
        cw_in = 5'b11111;
        tick();
        chk("t4_full2", 32'(cw_ready), 32'd0);
        cw_valid  = 1'b0;
        bit_ready = 1'b1;
        collect("t4a", 4, 16'b1100, 16'b1000, 16'b0000);
        chk("t4_rdy_last", 32'(cw_ready), 32'd0);
        collect("t4b", 1, 16'b1, 16'b0, 16'b1);
        chk("t4_rdy_pop", 32'(cw_ready), 32'd1);
        collect("t4c", 10, 16'b0010110011, 16'b1000010000, 16'b0000100001);
        chk("t4_endv", 32'(bit_valid), 32'd0);
        chk("t4_cnt",  32'(frame_cnt), 32'd3);
        chk("t4_busy", 32'(busy),      32'd0);

        // Reset mid-frame with one codeword queued
        cw_valid = 1'b1;
        cw_in    = 5'b01101;
        tick();
        cw_in = 5'b10010;
        tick();
        cw_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("t5_pre_v", 32'(bit_valid), 32'd1);
        chk("t5_pre_b", 32'(bit_out),   32'd0);
        rst = 1'b0;
        #1;
        chk("t5_rst_v",    32'(bit_valid), 32'd0);
        chk("t5_rst_cnt",  32'(frame_cnt), 32'd0);
        chk("t5_rst_rdy",  32'(cw_ready),  32'd1);
        chk("t5_rst_busy", 32'(busy),      32'd0);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("t5_quiet%0d", i), 32'(bit_valid), 32'd0);
        end
        cw_in    = 5'b00011;
        cw_valid = 1'b1;
        tick();
        cw_valid = 1'b0;
        tick();
        collect("t5", 5, 16'b00011, 16'b10000, 16'b00001);
        chk("t5_endv", 32'(bit_valid), 32'd0);
        chk("t5_cnt",  32'(frame_cnt), 32'd1);

        // LSB-first instance
        use_lsb    = 1'b1;
        l_cw_in    = 5'b10110;
        l_cw_valid = 1'b1;
        tick();
        l_cw_valid = 1'b0;
        tick();
        collect("t6", 5, 16'b01101, 16'b10000, 16'b00001);
        chk("t6_endv", 32'(l_bit_valid), 32'd0);
        chk("t6_cnt",  32'(l_frame_cnt), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
